// File: rtl/timer_counter.sv
// Programmable 32-bit down-counting timer with a bus register interface and a maskable interrupt.
// Supports one-shot (Mode 0, 2, 3) and auto-reload (Mode 1) operation.
module timer_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    state_t      state;
    logic        enable;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = sel && we && (addr == 2'd0);
    assign wr_preset = sel && we && (addr == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            enable   <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            // A register write clears the flag, but a flag raised on this same edge survives.
            if (wr_ctrl || wr_preset)
                irq_flag <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable)
                        state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (count <= 32'd1) begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    if (mode == 2'd1) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        enable <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase

            // Placed after the FSM so a CTRL write overrides the one-shot Enable clear.
            if (wr_ctrl) begin
                enable <= wdata[0];
                mode   <= wdata[2:1];
                im     <= wdata[3];
            end
            if (wr_preset)
                preset <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = {28'd0, im, mode, enable};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = '0;
        endcase
    end

    assign irq = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Randomised scoreboard bench for timer_counter: a period-level reference model predicts
// read data and irq for every cycle; a monitor compares after each rising edge.
`timescale 1ns/1ps
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    timer_counter dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  a;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: registers plus a description of the current timing period.
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    bit          m_active;   // timer started and not stopped
    bit          m_pending;  // a reload of PRESET happens on the next edge
    logic [31:0] m_per;      // PRESET captured for this period
    logic [31:0] m_steps;    // decrements elapsed in this period

    function automatic logic [31:0] period_len(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

    function automatic void model_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
        m_preset = 0; m_count = 0;
        m_active = 0; m_pending = 0; m_per = 0; m_steps = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic s, input logic w,
                                       input logic [1:0] a, input logic [31:0] d);
        bit          wr_c = s && w && (a == 2'd0);
        bit          wr_p = s && w && (a == 2'd1);
        bit          fired = 0;
        logic        n_en = m_en, n_flag = m_flag;
        logic [31:0] n_count = m_count, n_per = m_per, n_steps = m_steps;
        bit          n_active = m_active, n_pending = m_pending;

        if (!m_active) begin
            if (m_en) begin n_active = 1; n_pending = 1; end
        end else if (m_pending) begin
            n_pending = 0; n_per = m_preset; n_count = m_preset; n_steps = 0;
        end else if (m_steps == period_len(m_per)) begin
            if (m_mode == 2'd1) begin n_pending = 1; n_flag = 0; end
            else begin n_active = 0; n_en = 0; end
        end else if (!m_en) begin
            n_active = 0;
        end else begin
            n_steps = m_steps + 1;
            n_count = (n_steps >= m_per) ? 32'd0 : m_per - n_steps;
            if (n_steps == period_len(m_per)) begin n_flag = 1; fired = 1; end
        end

        if ((wr_c || wr_p) && !fired) n_flag = 0;
        if (wr_c) begin n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
        if (wr_p) m_preset = d;

        m_en = n_en; m_flag = n_flag; m_count = n_count; m_per = n_per;
        m_steps = n_steps; m_active = n_active; m_pending = n_pending;
    endfunction

    task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        sel = s; we = w; addr = a; wdata = d;
        model_step(s, w, a, d);
        e.rd = model_read(a); e.irq = m_im & m_flag; e.a = a;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, $urandom);
    endtask

    task automatic check_reset_now(input string tag);
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            checks++;
            if (rdata !== 32'd0) begin
                errors++;
                $display("FAIL %s rdata addr=%0d got=%h want=0", tag, a, rdata);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL %s irq got=%b want=0", tag, irq);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sel = 0; we = 0;
        #1 rst = 1'b1;
        model_reset();
        check_reset_now("async_reset");
        #1 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata !== e.rd) begin
                    errors++;
                    $display("FAIL rdata addr=%0d t=%0t got=%h want=%h", e.a, $time, rdata, e.rd);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("FAIL irq t=%0t got=%b want=%b", $time, irq, e.irq);
                end
            end
        end
    end

    initial begin : watchdog
        #(20 * 100000);
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_reset();
        #1;
        check_reset_now("power_on_reset");
        #2 rst = 1'b0;

        // One-shot, IM=1, PRESET=3; then a CTRL write clears irq.
        cyc(1, 1, 2'd1, 32'd3);
        cyc(1, 1, 2'd0, 32'h9);
        idle(8, 2'd2);
        idle(2, 2'd0);
        cyc(1, 1, 2'd0, 32'h8);
        idle(3, 2'd0);

        // Auto-reload PRESET=2, then stop.
        cyc(1, 1, 2'd1, 32'd2);
        cyc(1, 1, 2'd0, 32'hB);
        idle(14, 2'd2);
        cyc(1, 1, 2'd0, 32'h0);
        idle(4, 2'd2);

        // IM=0: irq never rises; later IM=1 write also clears the flag.
        cyc(1, 1, 2'd0, 32'h1);
        idle(6, 2'd2);
        cyc(1, 1, 2'd0, 32'h8);
        idle(3, 2'd0);

        // Freeze at 5, then re-enable reloads PRESET.
        cyc(1, 1, 2'd1, 32'd8);
        cyc(1, 1, 2'd0, 32'h9);
        idle(4, 2'd2);
        cyc(1, 1, 2'd0, 32'h8);
        idle(4, 2'd2);
        cyc(1, 1, 2'd0, 32'h9);
        idle(12, 2'd2);

        // PRESET=0 behaves like PRESET=1.
        cyc(1, 1, 2'd1, 32'd0);
        cyc(1, 1, 2'd0, 32'hB);
        idle(8, 2'd2);
        cyc(1, 1, 2'd0, 32'h0);

        // Asynchronous reset mid-count in auto-reload.
        cyc(1, 1, 2'd1, 32'd20);
        cyc(1, 1, 2'd0, 32'hB);
        idle(10, 2'd2);
        do_reset();
        idle(6, 2'd2);

        // PRESET rewritten mid-period takes effect at the next reload.
        cyc(1, 1, 2'd1, 32'd4);
        cyc(1, 1, 2'd0, 32'hB);
        idle(2, 2'd2);
        cyc(1, 1, 2'd1, 32'd9);
        idle(20, 2'd2);
        cyc(1, 1, 2'd0, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 399) == 0) do_reset();
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            if ($urandom_range(0, 5) == 0) cyc(1'b1, 1'b1, a, d);
            else cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1)) & 1'b0, a, d);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
